// File: rtl/dptr_seq.sv
// 8051 DPTR (DPH:DPL) sequencer: immediate load, increment, and MOVX access over a
// req/ack external-memory bus with a bounded wait, plus direct SFR writes to DPL/DPH.
//
// state | meaning
// IDLE  | cmd_ready_o high, waiting for a command
// RD    | xm_rd_o asserted, waiting for xm_ack_i or timeout
// WR    | xm_wr_o asserted, waiting for xm_ack_i or timeout
// FIN   | one-cycle done_o (err_o if the access timed out)
module dptr_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] cmd_data_i,
  input  logic [7:0]  wdata_i,
  output logic        cmd_ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  input  logic        sfr_wr_i,
  input  logic [7:0]  sfr_addr_i,
  input  logic [7:0]  sfr_data_i,
  output logic [15:0] dptr_o,
  output logic [15:0] xm_addr_o,
  output logic [7:0]  xm_wdata_o,
  output logic        xm_rd_o,
  output logic        xm_wr_o,
  input  logic        xm_ack_i,
  input  logic [7:0]  xm_rdata_i
);

  localparam logic [1:0] OP_LOAD16  = 2'b00;
  localparam logic [1:0] OP_INC     = 2'b01;
  localparam logic [1:0] OP_MOVX_RD = 2'b10;
  localparam logic [1:0] OP_MOVX_WR = 2'b11;
  localparam logic [7:0] SFR_DPL    = 8'h82;
  localparam logic [7:0] SFR_DPH    = 8'h83;
  localparam logic [7:0] TO_CNT     = 8'(TIMEOUT);

  // One-hot so every output is a single flop bit and cannot glitch.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_RD   = 4'b0010,
    S_WR   = 4'b0100,
    S_FIN  = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dptr_q, dptr_d;
  logic [15:0] xm_addr_q, xm_addr_d;
  logic [7:0]  xm_wdata_q, xm_wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      dptr_q     <= 16'h0000;
      xm_addr_q  <= 16'h0000;
      xm_wdata_q <= 8'h00;
      rdata_q    <= 8'h00;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dptr_q     <= dptr_d;
      xm_addr_q  <= xm_addr_d;
      xm_wdata_q <= xm_wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dptr_d     = dptr_q;
    xm_addr_d  = xm_addr_q;
    xm_wdata_d = xm_wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    if (sfr_wr_i && (sfr_addr_i == SFR_DPL)) begin
      dptr_d[7:0] = sfr_data_i;
    end else if (sfr_wr_i && (sfr_addr_i == SFR_DPH)) begin
      dptr_d[15:8] = sfr_data_i;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          err_d = 1'b0;
          cnt_d = 8'h00;
          // LOAD16/INC override a same-edge SFR write; MOVX latches the pre-write pointer.
          case (cmd_op_i)
            OP_LOAD16: begin
              dptr_d  = cmd_data_i;
              state_d = S_FIN;
            end
            OP_INC: begin
              dptr_d  = dptr_q + 16'd1;
              state_d = S_FIN;
            end
            OP_MOVX_RD: begin
              xm_addr_d  = dptr_q;
              xm_wdata_d = wdata_i;
              state_d    = S_RD;
            end
            OP_MOVX_WR: begin
              xm_addr_d  = dptr_q;
              xm_wdata_d = wdata_i;
              state_d    = S_WR;
            end
          endcase
        end
      end
      S_RD, S_WR: begin
        if (xm_ack_i) begin
          state_d = S_FIN;
          if (state_q == S_RD) begin
            rdata_d = xm_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_CNT) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o = state_q[0];
  assign xm_rd_o     = state_q[1];
  assign xm_wr_o     = state_q[2];
  assign done_o      = state_q[3];
  assign err_o       = state_q[3] & err_q;
  assign dptr_o      = dptr_q;
  assign xm_addr_o   = xm_addr_q;
  assign xm_wdata_o  = xm_wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_dptr_seq.sv
// Bench for dptr_seq: a reference model pushes expected results per command into a
// scoreboard that is popped and compared when done_o pulses.
module tb_dptr_seq;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  wdata;
  logic        cmd_ready, done, err;
  logic [7:0]  rdata;
  logic        sfr_wr;
  logic [7:0]  sfr_addr, sfr_data;
  logic [15:0] dptr, xm_addr;
  logic [7:0]  xm_wdata;
  logic        xm_rd, xm_wr, xm_ack;
  logic [7:0]  xm_rdata;

  dptr_seq #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .wdata_i(wdata),
    .cmd_ready_o(cmd_ready), .done_o(done), .err_o(err), .rdata_o(rdata),
    .sfr_wr_i(sfr_wr), .sfr_addr_i(sfr_addr), .sfr_data_i(sfr_data),
    .dptr_o(dptr), .xm_addr_o(xm_addr), .xm_wdata_o(xm_wdata),
    .xm_rd_o(xm_rd), .xm_wr_o(xm_wr), .xm_ack_i(xm_ack), .xm_rdata_i(xm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dptr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          strobes;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_dptr = 16'h0000;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_wdata = 8'h00;
  logic [7:0]  m_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command (optionally with a same-edge SFR write) and queues its expected result.
  task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [7:0] wd,
                      input int ack_at, input logic [7:0] rd,
                      input logic sw, input logic [7:0] sa, input logic [7:0] sd);
    exp_t        e;
    logic [15:0] pre;
    chk("cmd_ready", cmd_ready, 1);
    pre = m_dptr;
    if (sw && sa == 8'h82) m_dptr[7:0] = sd;
    else if (sw && sa == 8'h83) m_dptr[15:8] = sd;
    e.err = 1'b0;
    e.strobes = 0;
    case (op)
      2'b00: m_dptr = data;
      2'b01: m_dptr = pre + 16'd1;
      default: begin
        m_addr = pre;
        m_wdata = wd;
        e.strobes = (ack_at != 0) ? ack_at : TO;
        e.err = (ack_at == 0);
        if (op == 2'b10 && ack_at != 0) m_rdata = rd;
      end
    endcase
    e.dptr = m_dptr;
    e.addr = m_addr;
    e.wdata = m_wdata;
    e.rdata = m_rdata;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; wdata = wd;
    sfr_wr = sw; sfr_addr = sa; sfr_data = sd;
    tick();
    cmd_valid = 1'b0; sfr_wr = 1'b0; cmd_data = 16'hDEAD; wdata = 8'hEE;
  endtask

  // Runs the bus side until done, then pops and compares the scoreboard entry.
  task automatic finish_cmd(input int ack_at, input logic [7:0] rd);
    int   n = 0;
    int   strobes = 0;
    exp_t e;
    while (!done && n < 100) begin
      if (xm_rd || xm_wr) begin
        strobes++;
        if (strobes == ack_at) begin
          xm_ack = 1'b1;
          xm_rdata = rd;
        end
      end
      tick();
      xm_ack = 1'b0;
      xm_rdata = 8'hE1;
      n++;
    end
    chk("done_seen", done, 1);
    chk("strobe_off", {xm_rd, xm_wr}, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("strobes", strobes, e.strobes);
      chk("err", err, e.err);
      chk("dptr", dptr, e.dptr);
      chk("xm_addr", xm_addr, e.addr);
      chk("xm_wdata", xm_wdata, e.wdata);
      chk("rdata", rdata, e.rdata);
    end
    tick();
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h82) m_dptr[7:0] = d;
    else if (a == 8'h83) m_dptr[15:8] = d;
    sfr_wr = 1'b1; sfr_addr = a; sfr_data = d;
    tick();
    sfr_wr = 1'b0;
    chk("sfr_dptr", dptr, m_dptr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0; wdata = 8'h0;
    sfr_wr = 1'b0; sfr_addr = 8'h0; sfr_data = 8'h0; xm_ack = 1'b0; xm_rdata = 8'h0;
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_dptr", dptr, 0);
    chk("rst_outs", {done, err, xm_rd, xm_wr}, 0);
    chk("rst_regs", {xm_addr, xm_wdata, rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    send(2'b00, 16'h12FE, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send(2'b01, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    end
    chk("inc_chain", dptr, 16'h1301);

    send(2'b00, 16'hFFFF, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    send(2'b01, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    sfr_write(8'h83, 8'hAB);
    sfr_write(8'h82, 8'hCD);
    sfr_write(8'h81, 8'h11);

    send(2'b00, 16'h0040, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    send(2'b10, 16'h0000, 8'h00, 3, 8'h5A, 1'b0, 8'h00, 8'h00); finish_cmd(3, 8'h5A);
    send(2'b11, 16'h0000, 8'h77, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    send(2'b11, 16'h0000, 8'h24, 1, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(1, 8'h00);

    send(2'b00, 16'h0010, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);
    send(2'b01, 16'h0000, 8'h00, 0, 8'h00, 1'b1, 8'h82, 8'h00); finish_cmd(0, 8'h00);
    send(2'b10, 16'h0000, 8'h00, 1, 8'h3C, 1'b1, 8'h83, 8'h99); finish_cmd(1, 8'h3C);
    chk("collide_hi", dptr, 16'h9911);

    // Reset in the second read strobe cycle: the queued entry must never complete.
    send(2'b10, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00);
    void'(sb.pop_back());
    tick();
    chk("rd_strobe2", xm_rd, 1);
    rst = 1'b1;
    #1;
    chk("rst_rd_drop", xm_rd, 0);
    chk("rst_dptr2", dptr, 0);
    chk("rst_ready2", cmd_ready, 1);
    m_dptr = 16'h0; m_addr = 16'h0; m_wdata = 8'h0; m_rdata = 8'h0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_done", done, 0);
      tick();
      if (i == 1) rst = 1'b0;
    end
    send(2'b00, 16'hBEEF, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'h00); finish_cmd(0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
